// File: rtl/twiddle_pkg.sv
// Shared constants, twiddle word layout and ROM address generator for the
// 8-point radix-2 DIF twiddle stage.
package twiddle_pkg;

    localparam int unsigned TF_W      = 8;
    localparam int unsigned TF_FRAC   = 6;
    localparam int unsigned FFT_N     = 8;
    localparam int unsigned TF_ADDR_W = 2;
    localparam int unsigned CNT_W     = 3;

    // Packed ROM word: cos in the upper byte, sin in the lower byte (Q1.6)
    typedef struct packed {
        logic signed [TF_W-1:0] c;
        logic signed [TF_W-1:0] s;
    } tf_word_t;

    // Twiddle ROM address for frame index n at the given DIF stage
    function automatic logic [TF_ADDR_W-1:0] tf_addr_calc(input int unsigned stage,
                                                          input logic [CNT_W-1:0] n);
        int unsigned g;
        int unsigned p;
        int unsigned k;
        g = FFT_N >> stage;
        if (g < 2) begin
            k = 0;
        end else begin
            p = 32'(n) % g;
            if (p < g / 2) k = 0;
            else           k = (p - g / 2) << stage;
        end
        return TF_ADDR_W'(k);
    endfunction

endpackage

// File: rtl/twiddle_apply_8_cmul.sv
// cmul_q6: two-stage pipelined complex multiply by a Q1.6 twiddle with
// round-half-up, and saturation when TWIDDLE_SAT_EN is defined (wrap otherwise).
module cmul_q6
    import twiddle_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     in_valid,
    input  logic                     in_sof,
    input  logic signed [DATA_W-1:0] in_re,
    input  logic signed [DATA_W-1:0] in_im,
    input  tf_word_t                 tf,
    output logic                     out_valid,
    output logic                     out_sof,
    output logic signed [DATA_W-1:0] out_re,
    output logic signed [DATA_W-1:0] out_im
);

    localparam int unsigned PROD_W = DATA_W + TF_W;
    localparam int unsigned SUM_W  = PROD_W + 1;
    localparam int unsigned RES_W  = SUM_W - TF_FRAC;
    localparam logic signed [SUM_W-1:0] RND = SUM_W'(1 << (TF_FRAC - 1));

    logic                     c_valid;
    logic                     c_sof;
    logic signed [PROD_W-1:0] p_rc, p_is, p_rs, p_ic;
    logic signed [TF_W-1:0]   tf_c_c, tf_s_c;
    logic signed [SUM_W-1:0]  sum_re_c, sum_im_c;
    logic signed [RES_W-1:0]  rnd_re_c, rnd_im_c;
    logic signed [DATA_W-1:0] res_re_c, res_im_c;

    assign tf_c_c = tf.c;
    assign tf_s_c = tf.s;

`ifdef TWIDDLE_SAT_EN
    localparam logic signed [RES_W-1:0] MAX_V = RES_W'({1'b0, {(DATA_W-1){1'b1}}});
    localparam logic signed [RES_W-1:0] MIN_V = ~MAX_V;

    function automatic logic signed [DATA_W-1:0] fit(input logic signed [RES_W-1:0] x);
        if (x > MAX_V)      return MAX_V[DATA_W-1:0];
        else if (x < MIN_V) return MIN_V[DATA_W-1:0];
        else                return x[DATA_W-1:0];
    endfunction
`else
    function automatic logic signed [DATA_W-1:0] fit(input logic signed [RES_W-1:0] x);
        return x[DATA_W-1:0];
    endfunction
`endif

    // Sum, round and fit the registered products
    always_comb begin
        sum_re_c = SUM_W'(p_rc) - SUM_W'(p_is) + RND;
        sum_im_c = SUM_W'(p_rs) + SUM_W'(p_ic) + RND;
        rnd_re_c = RES_W'(sum_re_c >>> TF_FRAC);
        rnd_im_c = RES_W'(sum_im_c >>> TF_FRAC);
        res_re_c = fit(rnd_re_c);
        res_im_c = fit(rnd_im_c);
    end

    // Stage C: register the four partial products
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_valid <= 1'b0;
            c_sof   <= 1'b0;
            p_rc    <= '0;
            p_is    <= '0;
            p_rs    <= '0;
            p_ic    <= '0;
        end else if (en) begin
            c_valid <= in_valid;
            c_sof   <= in_valid && in_sof;
            if (in_valid) begin
                p_rc <= PROD_W'(in_re) * PROD_W'(tf_c_c);
                p_is <= PROD_W'(in_im) * PROD_W'(tf_s_c);
                p_rs <= PROD_W'(in_re) * PROD_W'(tf_s_c);
                p_ic <= PROD_W'(in_im) * PROD_W'(tf_c_c);
            end
        end
    end

    // Stage D: output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
        end else if (en) begin
            out_valid <= c_valid;
            out_sof   <= c_valid && c_sof;
            if (c_valid) begin
                out_re <= res_re_c;
                out_im <= res_im_c;
            end
        end
    end

endmodule

// File: rtl/twiddle_apply_8.sv
// twiddle_apply_8: applies 8-point DIF twiddles to a streamed complex sequence.
// Stages: A (sample + ROM address), B (sample delay, ROM word), C/D (cmul_q6).
// Define TWIDDLE_SAT_EN to saturate results instead of wrapping them.
module twiddle_apply_8
    import twiddle_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned STAGE  = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_sof,
    input  logic signed [DATA_W-1:0] in_re,
    input  logic signed [DATA_W-1:0] in_im,
    output logic [TF_ADDR_W-1:0]     tf_addr,
    input  logic [2*TF_W-1:0]        tf_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_sof,
    output logic signed [DATA_W-1:0] out_re,
    output logic signed [DATA_W-1:0] out_im
);

    logic                     stall_c;
    logic                     adv_c;
    logic [CNT_W-1:0]         cnt;
    logic [CNT_W-1:0]         n_c;
    logic                     a_valid, a_sof;
    logic signed [DATA_W-1:0] a_re, a_im;
    logic                     b_valid, b_sof;
    logic signed [DATA_W-1:0] b_re, b_im;
    logic                     tf_stale;
    tf_word_t                 tf_save;
    tf_word_t                 tf_use_c;

    assign stall_c  = out_valid && !out_ready;
    assign adv_c    = !stall_c;
    assign in_ready = adv_c;
    assign n_c      = in_sof ? '0 : cnt;

    // The ROM keeps clocking the held address during a stall, so its output
    // moves on to the stage-A word; keep the stage-B word captured meanwhile.
    assign tf_use_c = tf_stale ? tf_save : tf_word_t'(tf_in);

    // Stage A: accept sample, advance frame counter, issue ROM address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid <= 1'b0;
            a_sof   <= 1'b0;
            a_re    <= '0;
            a_im    <= '0;
            tf_addr <= '0;
            cnt     <= '0;
        end else if (adv_c) begin
            a_valid <= in_valid;
            a_sof   <= in_valid && in_sof;
            if (in_valid) begin
                a_re    <= in_re;
                a_im    <= in_im;
                tf_addr <= tf_addr_calc(STAGE, n_c);
                cnt     <= n_c + CNT_W'(1);
            end
        end
    end

    // Stage B: delay the sample to line up with the ROM word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_valid <= 1'b0;
            b_sof   <= 1'b0;
            b_re    <= '0;
            b_im    <= '0;
        end else if (adv_c) begin
            b_valid <= a_valid;
            b_sof   <= a_valid && a_sof;
            if (a_valid) begin
                b_re <= a_re;
                b_im <= a_im;
            end
        end
    end

    // Capture the stage-B ROM word on the first stalled edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tf_stale <= 1'b0;
            tf_save  <= '0;
        end else if (stall_c) begin
            if (!tf_stale) begin
                tf_save  <= tf_word_t'(tf_in);
                tf_stale <= 1'b1;
            end
        end else begin
            tf_stale <= 1'b0;
        end
    end

    cmul_q6 #(
        .DATA_W (DATA_W)
    ) u_cmul (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (adv_c),
        .in_valid  (b_valid),
        .in_sof    (b_sof),
        .in_re     (b_re),
        .in_im     (b_im),
        .tf        (tf_use_c),
        .out_valid (out_valid),
        .out_sof   (out_sof),
        .out_re    (out_re),
        .out_im    (out_im)
    );

endmodule

// File: tb/tb_twiddle_apply_8.sv
// Directed bench for twiddle_apply_8 (STAGE=0) with a registered twiddle ROM.
`timescale 1ns/1ps
module tb_twiddle_apply_8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic               in_sof = 1'b0;
    logic signed [15:0] in_re = '0;
    logic signed [15:0] in_im = '0;
    logic [1:0]         tf_addr;
    logic [15:0]        tf_in = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic               out_sof;
    logic signed [15:0] out_re;
    logic signed [15:0] out_im;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic               sof;
        logic signed [15:0] re;
        logic signed [15:0] im;
    } obs_t;

    obs_t               oq[$];
    logic signed [15:0] fr_re[8];
    logic signed [15:0] fr_im[8];

    twiddle_apply_8 #(.DATA_W(16), .STAGE(0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sof    (in_sof),
        .in_re     (in_re),
        .in_im     (in_im),
        .tf_addr   (tf_addr),
        .tf_in     (tf_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sof   (out_sof),
        .out_re    (out_re),
        .out_im    (out_im)
    );

    always #5 clk = ~clk;

    // Registered twiddle ROM: {cos, sin} in Q1.6 for W8^k, k = 0..3
    always @(posedge clk) begin
        case (tf_addr)
            2'd0:    tf_in <= 16'h4000;   // ( 64,   0)
            2'd1:    tf_in <= 16'h2DD3;   // ( 45, -45)
            2'd2:    tf_in <= 16'h00C0;   // (  0, -64)
            default: tf_in <= 16'hD3D3;   // (-45, -45)
        endcase
    end

    // Output capture on each completed handshake
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) oq.push_back({out_sof, out_re, out_im});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_one(input logic signed [15:0] re, input logic signed [15:0] im,
                             input logic sof);
        in_valid = 1'b1;
        in_re    = re;
        in_im    = im;
        in_sof   = sof;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic wait_out(input int n);
        int t;
        t = 0;
        while (oq.size() < n && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        idle(3);
        tests++;
        if (oq.size() != n) begin
            fails++;
            $display("FAIL drain_count: got %0d outputs, expected %0d", oq.size(), n);
        end
    endtask

    task automatic send_frame();
        oq.delete();
        for (int k = 0; k < 8; k++) drive_one(fr_re[k], fr_im[k], k == 0);
        wait_out(8);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (in_ready !== 1'b1)  begin fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        tests++; if (out_sof !== 1'b0)   begin fails++; $display("FAIL reset_out_sof: got %b expected 0", out_sof); end
        tests++; if (tf_addr !== 2'd0)   begin fails++; $display("FAIL reset_tf_addr: got %0d expected 0", tf_addr); end
        tests++; if (out_re !== 16'sd0)  begin fails++; $display("FAIL reset_out_re: got %0d expected 0", out_re); end
        tests++; if (out_im !== 16'sd0)  begin fails++; $display("FAIL reset_out_im: got %0d expected 0", out_im); end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_addr_seq();
        int exp_a[8] = '{0, 0, 0, 0, 0, 1, 2, 3};
        oq.delete();
        for (int k = 0; k < 8; k++) begin
            if (k == 5) idle(1);   // bubble: counter must hold
            drive_one(16'(k * 10), 16'sd0, k == 0);
            tests++;
            if (tf_addr !== 2'(exp_a[k])) begin
                fails++;
                $display("FAIL addr_seq[%0d]: got %0d expected %0d", k, tf_addr, exp_a[k]);
            end
            if (k == 1 || k == 2) begin
                tests++;
                if (out_valid !== 1'b0) begin fails++; $display("FAIL latency_early[%0d]: out_valid %b expected 0", k, out_valid); end
            end
            if (k == 3) begin
                tests++;
                if (out_valid !== 1'b1) begin fails++; $display("FAIL latency_3: out_valid %b expected 1", out_valid); end
            end
        end
        wait_out(8);
    endtask

    task automatic test_arith();
        int               idx[3]  = '{0, 5, 6};
        logic signed [15:0] er[3] = '{16'sd123, 16'sd703, 16'sd200};
        logic signed [15:0] ei[3] = '{-16'sd456, -16'sd703, -16'sd100};
        obs_t e;
        for (int k = 0; k < 8; k++) begin fr_re[k] = '0; fr_im[k] = '0; end
        fr_re[0] = 16'sd123;  fr_im[0] = -16'sd456;
        fr_re[5] = 16'sd1000; fr_im[5] = 16'sd0;
        fr_re[6] = 16'sd100;  fr_im[6] = 16'sd200;
        send_frame();
        for (int j = 0; j < 3; j++) begin
            e = oq[idx[j]];
            tests++;
            if (e.re !== er[j] || e.im !== ei[j]) begin
                fails++;
                $display("FAIL arith_n%0d: got (%0d,%0d) expected (%0d,%0d)", idx[j],
                         $signed(e.re), $signed(e.im), er[j], ei[j]);
            end
        end
        e = oq[0];
        tests++;
        if (e.sof !== 1'b1) begin fails++; $display("FAIL arith_sof: got %b expected 1", e.sof); end
    endtask

    task automatic test_saturation();
        logic signed [15:0] exp_re;
        obs_t e;
`ifdef TWIDDLE_SAT_EN
        exp_re = 16'sd32767;
`else
        exp_re = -16'sd19457;
`endif
        for (int k = 0; k < 8; k++) begin fr_re[k] = '0; fr_im[k] = '0; end
        fr_re[5] = 16'sd32767; fr_im[5] = 16'sd32767;
        send_frame();
        e = oq[5];
        tests++;
        if (e.re !== exp_re || e.im !== 16'sd0) begin
            fails++;
            $display("FAIL saturation: got (%0d,%0d) expected (%0d,0)", $signed(e.re), $signed(e.im), exp_re);
        end
    endtask

    task automatic test_back_to_back();
        logic               pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic signed [15:0] er[8]  = '{16'sd64, 16'sd128, 16'sd192, 16'sd256, 16'sd320,
                                       16'sd270, 16'sd0, -16'sd360};
        logic signed [15:0] ei[8]  = '{16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0,
                                       -16'sd270, -16'sd448, -16'sd360};
        int   k;
        int   cyc;
        logic acc;
        logic stl;
        logic [1:0] a0;
        obs_t e;
        for (int i = 0; i < 8; i++) begin fr_re[i] = 16'((i + 1) * 64); fr_im[i] = '0; end
        oq.delete();
        k = 0;
        cyc = 0;
        while ((k < 8 || oq.size() < 8) && cyc < 200) begin
            out_ready = pat[cyc % 4];
            in_valid  = (k < 8);
            in_sof    = (k == 0);
            in_re     = fr_re[k % 8];
            in_im     = fr_im[k % 8];
            @(negedge clk);
            acc = in_valid && in_ready;
            stl = out_valid && !out_ready;
            a0  = tf_addr;
            @(posedge clk);
            #1;
            if (stl) begin
                tests++;
                if (tf_addr !== a0) begin fails++; $display("FAIL stall_tf_addr: got %0d expected %0d", tf_addr, a0); end
            end
            if (acc) k++;
            cyc++;
        end
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        out_ready = 1'b1;
        tests++;
        if (k != 8) begin fails++; $display("FAIL bp_accepts: got %0d expected 8", k); end
        wait_out(8);
        for (int i = 0; i < 8; i++) begin
            e = oq[i];
            tests++;
            if (e.re !== er[i] || e.im !== ei[i] || e.sof !== (i == 0)) begin
                fails++;
                $display("FAIL bp_out[%0d]: got (%0d,%0d,sof=%b) expected (%0d,%0d,sof=%b)", i,
                         $signed(e.re), $signed(e.im), e.sof, er[i], ei[i], i == 0);
            end
        end
    endtask

    task automatic test_resync();
        int exp_a[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 2};
        for (int k = 0; k < 10; k++) begin
            drive_one(16'sd5, 16'sd5, k == 0 || k == 3);
            tests++;
            if (tf_addr !== 2'(exp_a[k])) begin
                fails++;
                $display("FAIL resync_addr[%0d]: got %0d expected %0d", k, tf_addr, exp_a[k]);
            end
        end
        idle(6);
        oq.delete();
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 4; k++) drive_one(16'sd7, 16'sd7, k == 0);
        tests++;
        if (out_valid !== 1'b1) begin fails++; $display("FAIL mid_pre_valid: got %b expected 1", out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_reset_valid: got %b expected 0", out_valid); end
        tests++; if (tf_addr !== 2'd0)   begin fails++; $display("FAIL mid_reset_addr: got %0d expected 0", tf_addr); end
        tests++; if (in_ready !== 1'b1)  begin fails++; $display("FAIL mid_reset_ready: got %b expected 1", in_ready); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        for (int k = 0; k < 6; k++) drive_one(16'sd9, 16'sd9, 1'b0);
        tests++;
        if (tf_addr !== 2'd1) begin fails++; $display("FAIL mid_counter_restart: got %0d expected 1", tf_addr); end
        idle(6);
        oq.delete();
    endtask

    initial begin
        test_reset();
        test_addr_seq();
        test_arith();
        test_saturation();
        test_back_to_back();
        test_resync();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
